// File: rtl/branch_config_sequencer.sv
// Configuration write sequencer for the branch module array: takes one request at a
// time and issues its write enable in the cycle that the request's thread owns the config stage.
module branch_config_sequencer #(
  parameter int WORD_WIDTH         = 36,
  parameter int MODULE_COUNT       = 4,
  parameter int MODULE_COUNT_WIDTH = 2,
  parameter int THREAD_COUNT       = 8,
  parameter int THREAD_COUNT_WIDTH = 3
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic [THREAD_COUNT_WIDTH-1:0] current_thread,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [THREAD_COUNT_WIDTH-1:0] req_thread,
  input  logic [MODULE_COUNT_WIDTH-1:0] req_module,
  input  logic                          req_broadcast,
  input  logic [1:0]                    req_target,
  input  logic                          req_addr,
  input  logic [WORD_WIDTH-1:0]         req_data,
  output logic [MODULE_COUNT-1:0]       bs1_config_wren,
  output logic [MODULE_COUNT-1:0]       bs2_config_wren,
  output logic [MODULE_COUNT-1:0]       bd_config_wren,
  output logic [MODULE_COUNT-1:0]       bc_config_wren,
  output logic                          config_addr,
  output logic [WORD_WIDTH-1:0]         config_data,
  output logic                          busy,
  output logic                          error,
  output logic [15:0]                   write_count
);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t                          state, state_next;
  logic [THREAD_COUNT_WIDTH-1:0]   held_thread;
  logic [MODULE_COUNT_WIDTH-1:0]   held_module;
  logic                            held_broadcast;
  logic [1:0]                      held_target;
  logic                            capture;
  logic                            bad_request;
  logic                            match;
  logic [MODULE_COUNT-1:0]         select;

  // A thread index that never comes round would otherwise park the sequencer forever.
  assign bad_request = (!req_broadcast && (int'(req_module) >= MODULE_COUNT)) ||
                       (int'(req_thread) >= THREAD_COUNT);
  assign match       = (state == WAIT) && (current_thread == held_thread);
  assign req_ready   = (state == IDLE);
  assign busy        = (state == WAIT);

  always_comb begin
    state_next = state;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          capture = 1'b1;
          if (!bad_request) state_next = WAIT;
        end
      end
      WAIT: begin
        if (match) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    select = '0;
    for (int i = 0; i < MODULE_COUNT; i++) begin
      select[i] = held_broadcast || (int'(held_module) == i);
    end
  end

  always_comb begin
    bs1_config_wren = '0;
    bs2_config_wren = '0;
    bd_config_wren  = '0;
    bc_config_wren  = '0;
    if (match) begin
      case (held_target)
        2'd0:    bs1_config_wren = select;
        2'd1:    bs2_config_wren = select;
        2'd2:    bd_config_wren  = select;
        default: bc_config_wren  = select;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      held_thread    <= '0;
      held_module    <= '0;
      held_broadcast <= 1'b0;
      held_target    <= '0;
      config_addr    <= 1'b0;
      config_data    <= '0;
      error          <= 1'b0;
      write_count    <= '0;
    end else begin
      state <= state_next;
      error <= capture && bad_request;
      if (capture) begin
        held_thread    <= req_thread;
        held_module    <= req_module;
        held_broadcast <= req_broadcast;
        held_target    <= req_target;
        config_addr    <= req_addr;
        config_data    <= req_data;
      end
      if (match) write_count <= write_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_branch_config_sequencer.sv
// Scoreboard bench for branch_config_sequencer: accepted requests are queued with their
// expected write cycle and matched against each wren pulse the sequencer produces.
module tb_branch_config_sequencer;

  localparam int WW = 36;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic [2:0]    current_thread = 3'd0;

  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [2:0]    req_thread = '0;
  logic [1:0]    req_module = '0;
  logic          req_broadcast = 1'b0;
  logic [1:0]    req_target = '0;
  logic          req_addr = 1'b0;
  logic [WW-1:0] req_data = '0;
  logic [3:0]    bs1_config_wren, bs2_config_wren, bd_config_wren, bc_config_wren;
  logic          config_addr;
  logic [WW-1:0] config_data;
  logic          busy, error;
  logic [15:0]   write_count;

  logic          req2_valid = 1'b0;
  logic          req2_ready;
  logic [1:0]    req2_module = '0;
  logic [2:0]    bs1_wren2, bs2_wren2, bd_wren2, bc_wren2;
  logic          config_addr2;
  logic [WW-1:0] config_data2;
  logic          busy2, error2;
  logic [15:0]   write_count2;

  branch_config_sequencer dut (
    .clock(clock), .reset_n(reset_n), .current_thread(current_thread),
    .req_valid(req_valid), .req_ready(req_ready), .req_thread(req_thread),
    .req_module(req_module), .req_broadcast(req_broadcast), .req_target(req_target),
    .req_addr(req_addr), .req_data(req_data),
    .bs1_config_wren(bs1_config_wren), .bs2_config_wren(bs2_config_wren),
    .bd_config_wren(bd_config_wren), .bc_config_wren(bc_config_wren),
    .config_addr(config_addr), .config_data(config_data),
    .busy(busy), .error(error), .write_count(write_count)
  );

  // Three-module instance so that an out-of-range module index is expressible.
  branch_config_sequencer #(.MODULE_COUNT(3)) dut_small (
    .clock(clock), .reset_n(reset_n), .current_thread(current_thread),
    .req_valid(req2_valid), .req_ready(req2_ready), .req_thread(3'd4),
    .req_module(req2_module), .req_broadcast(1'b0), .req_target(2'd3),
    .req_addr(1'b1), .req_data(36'hABCDE),
    .bs1_config_wren(bs1_wren2), .bs2_config_wren(bs2_wren2),
    .bd_config_wren(bd_wren2), .bc_config_wren(bc_wren2),
    .config_addr(config_addr2), .config_data(config_data2),
    .busy(busy2), .error(error2), .write_count(write_count2)
  );

  typedef struct {
    logic [15:0]   wren;
    logic          addr;
    logic [WW-1:0] data;
    int            exp_cycle;
  } exp_t;

  exp_t        sb[$];
  int          wren_cycles[$];
  int          cycle_num = 0;
  int          checks = 0;
  int          fails = 0;
  logic [15:0] model_count = '0;
  bit          ready_pending = 0;

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic applyStimulus(input logic [2:0] thr, input logic [1:0] mdl, input logic bc,
                               input logic [1:0] tgt, input logic adr, input logic [WW-1:0] dat);
    bit accepted = 0;
    req_thread    = thr;
    req_module    = mdl;
    req_broadcast = bc;
    req_target    = tgt;
    req_addr      = adr;
    req_data      = dat;
    req_valid     = 1'b1;
    for (int i = 0; i < 50 && !accepted; i++) begin
      @(negedge clock);
      if (req_ready) accepted = 1;
      step();
    end
    req_valid = 1'b0;
    if (!accepted) checkOutput("accept_timeout", 0, 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && sb.size() > 0; i++) @(negedge clock);
    checkOutput("drain_empty", sb.size(), 0);
    step();
  endtask

  initial forever begin
    @(posedge clock);
    #1;
    current_thread = current_thread + 3'd1;
  end

  // Monitor: matches wren pulses against the queue and enqueues each accepted request.
  initial forever begin
    logic [15:0] wren_all;
    @(negedge clock);
    cycle_num++;
    if (!reset_n) continue;
    wren_all = {bs1_config_wren, bs2_config_wren, bd_config_wren, bc_config_wren};
    if (ready_pending) begin
      checkOutput("ready_after_wren", req_ready, 1);
      ready_pending = 0;
    end
    if (wren_all != 16'd0) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_wren", wren_all, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("wren_vectors", wren_all, e.wren);
        checkOutput("wren_cycle", cycle_num, e.exp_cycle);
        checkOutput("config_addr", config_addr, e.addr);
        checkOutput("config_data", config_data, e.data);
        checkOutput("busy_at_wren", {busy, req_ready, error}, 3'b100);
        checkOutput("count_at_wren", write_count, model_count);
        model_count++;
        wren_cycles.push_back(cycle_num);
        ready_pending = 1;
      end
    end else if (sb.size() > 0 && cycle_num >= sb[0].exp_cycle) begin
      checkOutput("missing_wren", 0, 1);
      void'(sb.pop_front());
    end
    if (req_valid && req_ready) begin
      exp_t        e;
      logic [3:0]  one;
      logic [3:0]  vec;
      logic [2:0]  diff;
      one  = 4'b0001;
      vec  = req_broadcast ? 4'b1111 : (one << req_module);
      diff = req_thread - current_thread;
      e.wren      = {12'd0, vec} << (4 * (3 - int'(req_target)));
      e.addr      = req_addr;
      e.data      = req_data;
      e.exp_cycle = cycle_num + ((diff == 3'd0) ? 8 : int'(diff));
      sb.push_back(e);
    end
  end

  initial begin
    int n;
    repeat (3) step();
    reset_n = 1'b1;

    // Idle after reset.
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      checkOutput("idle_ready", req_ready, 1);
      checkOutput("idle_wren", {bs1_config_wren, bs2_config_wren, bd_config_wren, bc_config_wren}, 0);
      checkOutput("idle_count", write_count, 0);
    end
    step();

    // Detector write aligned to thread 0 acceptance.
    for (int i = 0; i < 8 && current_thread != 3'd0; i++) step();
    applyStimulus(3'd5, 2'd2, 1'b0, 2'd2, 1'b0, 36'h123456789);
    drain();

    // Broadcast sentinel-1 write.
    applyStimulus(3'd3, 2'd0, 1'b1, 2'd0, 1'b1, 36'hF0F0F0F0F);
    drain();

    // Mixed targets, modules and threads.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(3'($urandom_range(0, 7)), 2'(i), 1'(i == 5), 2'(i), 1'(i % 2),
                    {4'(i), 32'($urandom)});
    end
    drain();

    // Bad module index on the three-module instance.
    req2_module = 2'd3;
    req2_valid  = 1'b1;
    @(negedge clock);
    checkOutput("bad_ready", req2_ready, 1);
    checkOutput("bad_error_early", error2, 0);
    step();
    req2_valid = 1'b0;
    @(negedge clock);
    checkOutput("bad_error_pulse", error2, 1);
    checkOutput("bad_ready_after", {req2_ready, busy2}, 2'b10);
    checkOutput("bad_no_wren", {bs1_wren2, bs2_wren2, bd_wren2, bc_wren2}, 0);
    @(negedge clock);
    checkOutput("bad_error_clear", error2, 0);
    checkOutput("bad_count", write_count2, 0);
    step();

    // Back-to-back requests to the same thread.
    n = wren_cycles.size();
    applyStimulus(3'd1, 2'd1, 1'b0, 2'd3, 1'b0, 36'h111111111);
    applyStimulus(3'd1, 2'd3, 1'b0, 2'd1, 1'b1, 36'h222222222);
    drain();
    if (wren_cycles.size() >= n + 2)
      checkOutput("b2b_spacing", wren_cycles[n+1] - wren_cycles[n], 8);
    else
      checkOutput("b2b_wren_seen", wren_cycles.size() - n, 2);
    checkOutput("count_mid", write_count, model_count);

    // Reset in WAIT before the thread match drops the request.
    applyStimulus(current_thread, 2'd0, 1'b0, 2'd2, 1'b1, 36'h9ABCDEF01);
    step();
    step();
    checkOutput("pre_reset_busy", busy, 1);
    reset_n = 1'b0;
    sb.delete();
    model_count   = '0;
    ready_pending = 0;
    #1;
    checkOutput("reset_wren", {bs1_config_wren, bs2_config_wren, bd_config_wren, bc_config_wren}, 0);
    checkOutput("reset_busy_err", {busy, error}, 0);
    checkOutput("reset_count", write_count, 0);
    checkOutput("reset_data", {config_addr, config_data}, 0);
    step();
    step();
    reset_n = 1'b1;
    repeat (20) step();
    checkOutput("reset_idle", {req_ready, busy}, 2'b10);

    checkOutput("final_count", write_count, model_count);
    checkOutput("final_sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
